// File: rtl/mp_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mp_wr_ctrl
// Purpose  : Merges host (FIFO-buffered), core and interrupt writes onto one
//            registered register-file write port with region-based masking.
// Revision : 1.0
// ============================================================================
module mp_wr_ctrl #(
    parameter int                DATA_W     = 64,
    parameter int                BUS_W      = 32,
    parameter int                INST_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] INT_ADDR   = ADDR_W'(16'h0021)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [BUS_W-1:0]  s_din,
    output logic              s_full,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] to_Rd,
    input  logic              op_done,
    output logic              w_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_wData,
    output logic              ovf,
    output logic              bad_addr,
    output logic              int_pend
);

    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [3:0]     REG_DATA = 4'h0;
    localparam logic [3:0]     REG_INST = 4'h1;
    localparam logic [3:0]     REG_CONT = 4'h2;

    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [BUS_W-1:0]  data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              int_pend_q, int_pend_d;
    logic              w_we_q, w_we_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_wData_q, w_wData_d;
    logic              ovf_q, ovf_d;
    logic              bad_addr_q, bad_addr_d;

    logic              full, push, pop, issue_int;
    logic [ADDR_W-1:0] head_addr;
    logic [BUS_W-1:0]  head_data;

    assign full      = (count_q == FULL_CNT);
    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];

    always_comb begin
        push       = s_wr && !full;
        issue_int  = !core_we && int_pend_q;
        pop        = !core_we && !int_pend_q && (count_q != '0);
        w_we_d     = 1'b0;
        w_addr_d   = w_addr_q;
        w_wData_d  = w_wData_q;
        bad_addr_d = 1'b0;
        if (core_we) begin
            w_we_d    = 1'b1;
            w_addr_d  = core_addr;
            w_wData_d = to_Rd;
        end else if (issue_int) begin
            w_we_d    = 1'b1;
            w_addr_d  = INT_ADDR;
            w_wData_d = DATA_W'(1'b1);
        end else if (pop) begin
            // Undefined regions are consumed silently apart from bad_addr
            case (head_addr[7:4])
                REG_DATA: begin
                    w_we_d    = 1'b1;
                    w_addr_d  = head_addr;
                    w_wData_d = DATA_W'(head_data);
                end
                REG_INST: begin
                    w_we_d    = 1'b1;
                    w_addr_d  = head_addr;
                    w_wData_d = DATA_W'(head_data[INST_W-1:0]);
                end
                REG_CONT: begin
                    w_we_d    = 1'b1;
                    w_addr_d  = head_addr;
                    w_wData_d = DATA_W'(head_data[0]);
                end
                default: bad_addr_d = 1'b1;
            endcase
        end
        ovf_d      = s_wr && full;
        int_pend_d = op_done || (int_pend_q && !issue_int);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            int_pend_q <= 1'b0;
            w_we_q     <= 1'b0;
            w_addr_q   <= '0;
            w_wData_q  <= '0;
            ovf_q      <= 1'b0;
            bad_addr_q <= 1'b0;
        end else begin
            if (push) begin
                addr_mem_q[wr_ptr_q] <= s_addr;
                data_mem_q[wr_ptr_q] <= s_din;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            int_pend_q <= int_pend_d;
            w_we_q     <= w_we_d;
            w_addr_q   <= w_addr_d;
            w_wData_q  <= w_wData_d;
            ovf_q      <= ovf_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign s_full   = full;
    assign w_we     = w_we_q;
    assign w_addr   = w_addr_q;
    assign w_wData  = w_wData_q;
    assign ovf      = ovf_q;
    assign bad_addr = bad_addr_q;
    assign int_pend = int_pend_q;

endmodule
`default_nettype wire
